// File: rtl/lpm_mult_seq_pkg.sv
// Shared types and elaboration-time helpers for the sequential multiplier.
package lpm_mult_seq_pkg;

  // Controller states: idle, shift-add iterations, sign fix-up / output mapping.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_e;

  // Ceiling log2, used to size the iteration counter.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // Width of the exact (untruncated) product.
  function automatic int PW(input int wa, input int wb);
    return wa + wb;
  endfunction

endpackage

// File: rtl/lpm_mult_seq_mag.sv
// Conditional two's-complement negate. Used both to take operand magnitudes
// and to restore the sign of the finished product.
module lpm_mult_seq_mag #(
  parameter int W = 16
) (
  input  logic         neg,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  assign dout = neg ? -din : din;

endmodule

// File: rtl/lpm_mult_seq.sv
// Multi-cycle WIDTHA x WIDTHB multiplier: one shift-add step per clock on
// operand magnitudes, sign restored at the end, product mapped to WIDTHP.
module lpm_mult_seq
  import lpm_mult_seq_pkg::*;
#(
  parameter int WIDTHA = 16,
  parameter int WIDTHB = 16,
  parameter int WIDTHP = 32
) (
  input  logic              Clock,
  input  logic              Aclr_n,
  input  logic              Start,
  input  logic              Signed_,
  input  logic [WIDTHA-1:0] DataA,
  input  logic [WIDTHB-1:0] DataB,
  output logic              Busy,
  output logic              Done,
  output logic [WIDTHP-1:0] Result
);

  localparam int FW = PW(WIDTHA, WIDTHB);  // exact product width
  localparam int AW = FW + 1;              // accumulator width (one carry bit)
  localparam int CW = clog2(WIDTHB);       // iteration counter width
  localparam logic [CW-1:0] LAST = CW'(WIDTHB - 1);

  state_e            state_q, state_d;
  logic              signed_q, signed_d;
  logic              neg_q, neg_d;
  logic [WIDTHA-1:0] ma_q, ma_d;
  logic [WIDTHB-1:0] mb_q, mb_d;
  logic [AW-1:0]     acc_q, acc_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [WIDTHP-1:0] result_q, result_d;

  logic              neg_a, neg_b;
  logic [WIDTHA-1:0] abs_a;
  logic [WIDTHB-1:0] abs_b;
  logic [FW-1:0]     full;
  logic [WIDTHP-1:0] mapped;
  logic [WIDTHA:0]   sum;
  logic [AW-1:0]     step;

  // Magnitudes only differ from the raw operand for negative signed inputs;
  // an unsigned WIDTHA-bit magnitude holds the most-negative value exactly.
  assign neg_a = Signed_ & DataA[WIDTHA-1];
  assign neg_b = Signed_ & DataB[WIDTHB-1];

  lpm_mult_seq_mag #(.W(WIDTHA)) u_mag_a (
    .neg  (neg_a),
    .din  (DataA),
    .dout (abs_a)
  );

  lpm_mult_seq_mag #(.W(WIDTHB)) u_mag_b (
    .neg  (neg_b),
    .din  (DataB),
    .dout (abs_b)
  );

  // Final sign fix-up of the unsigned magnitude product.
  lpm_mult_seq_mag #(.W(FW)) u_mag_p (
    .neg  (neg_q),
    .din  (acc_q[FW-1:0]),
    .dout (full)
  );

  // Map the exact product onto the output width: pass, extend, or keep the MSBs.
  generate
    if (WIDTHP == FW) begin : g_map_eq
      assign mapped = full;
    end else if (WIDTHP > FW) begin : g_map_ext
      assign mapped = {{(WIDTHP - FW){signed_q & full[FW-1]}}, full};
    end else begin : g_map_trunc
      assign mapped = full[FW-1 -: WIDTHP];
    end
  endgenerate

  // One shift-add step: add the multiplicand into the upper part, then shift right.
  // The upper part is below 2^WIDTHA after every shift, so the sum never overflows.
  assign sum  = acc_q[AW-1:WIDTHB] + (mb_q[0] ? {1'b0, ma_q} : '0);
  assign step = {sum, acc_q[WIDTHB-1:0]} >> 1;

  // Next-state and next-output logic for the controller and datapath.
  always_comb begin
    state_d  = state_q;
    signed_d = signed_q;
    neg_d    = neg_q;
    ma_d     = ma_q;
    mb_d     = mb_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (Start) begin
          signed_d = Signed_;
          neg_d    = Signed_ & (DataA[WIDTHA-1] ^ DataB[WIDTHB-1]);
          ma_d     = abs_a;
          mb_d     = abs_b;
          acc_d    = '0;
          cnt_d    = '0;
          busy_d   = 1'b1;
          state_d  = RUN;
        end
      end
      RUN: begin
        acc_d = step;
        mb_d  = mb_q >> 1;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) state_d = FIN;
      end
      FIN: begin
        result_d = mapped;
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs; the asynchronous clear aborts any operation.
  always_ff @(posedge Clock or negedge Aclr_n) begin
    if (!Aclr_n) begin
      state_q  <= IDLE;
      signed_q <= 1'b0;
      neg_q    <= 1'b0;
      ma_q     <= '0;
      mb_q     <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      signed_q <= signed_d;
      neg_q    <= neg_d;
      ma_q     <= ma_d;
      mb_q     <= mb_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign Busy   = busy_q;
  assign Done   = done_q;
  assign Result = result_q;

endmodule

// File: tb/tb_lpm_mult_seq.sv
// Directed bench for lpm_mult_seq: three 16x16 instances (32/16/40-bit results)
// driven in parallel, plus a 5x3 -> 12 instance for a short randomised sweep.
module tb_lpm_mult_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start, sgn;
  logic [15:0] a, b;
  logic        busy0, done0, busy1, done1, busy2, done2;
  logic [31:0] res0;
  logic [15:0] res1;
  logic [39:0] res2;

  logic        start3, sgn3;
  logic [4:0]  a3;
  logic [2:0]  b3;
  logic        busy3, done3;
  logic [11:0] res3;

  int n_tests = 0;
  int n_fail  = 0;

  lpm_mult_seq #(.WIDTHA(16), .WIDTHB(16), .WIDTHP(32)) dut0 (
    .Clock(clk), .Aclr_n(rst_n), .Start(start), .Signed_(sgn), .DataA(a), .DataB(b),
    .Busy(busy0), .Done(done0), .Result(res0));
  lpm_mult_seq #(.WIDTHA(16), .WIDTHB(16), .WIDTHP(16)) dut1 (
    .Clock(clk), .Aclr_n(rst_n), .Start(start), .Signed_(sgn), .DataA(a), .DataB(b),
    .Busy(busy1), .Done(done1), .Result(res1));
  lpm_mult_seq #(.WIDTHA(16), .WIDTHB(16), .WIDTHP(40)) dut2 (
    .Clock(clk), .Aclr_n(rst_n), .Start(start), .Signed_(sgn), .DataA(a), .DataB(b),
    .Busy(busy2), .Done(done2), .Result(res2));
  lpm_mult_seq #(.WIDTHA(5), .WIDTHB(3), .WIDTHP(12)) dut3 (
    .Clock(clk), .Aclr_n(rst_n), .Start(start3), .Signed_(sgn3), .DataA(a3), .DataB(b3),
    .Busy(busy3), .Done(done3), .Result(res3));

  typedef struct packed {
    logic        s;
    logic [15:0] va;
    logic [15:0] vb;
    logic [31:0] e32;
    logic [15:0] e16;
    logic [39:0] e40;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present an operation for one sampling edge (called at a falling edge).
  task automatic launch(input logic s, input logic [15:0] va, input logic [15:0] vb);
    start = 1'b1; sgn = s; a = va; b = vb;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Wait for Done on the 16x16 instances, checking latency and Busy framing.
  // With pulse set, Start is strobed with junk operands while busy.
  task automatic wait_check(input string tag, input bit pulse);
    int lat, busy_cyc;
    lat = 0; busy_cyc = 0;
    while (!done0 && lat < 60) begin
      if (busy0) busy_cyc++;
      if (pulse) begin
        start = (lat % 3 == 1);
        a = 16'hA5A5; b = 16'h5A5A; sgn = ~sgn;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    chk({tag, " done"}, done0, 1);
    chk({tag, " latency"}, lat, 17);
    chk({tag, " busy_cycles"}, busy_cyc, 17);
    chk({tag, " busy_in_done"}, busy0, 0);
    chk({tag, " done1_align"}, done1, 1);
    chk({tag, " done2_align"}, done2, 1);
  endtask

  task automatic count_dones(input string tag, input int cycles, input int exp);
    int n;
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done0) n++;
    end
    chk(tag, n, exp);
  endtask

  initial begin
    logic [63:0] p;
    int lat3;

    vecs[0] = '{1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001, 16'hFFFE, 40'h00FFFE0001};
    vecs[1] = '{1'b1, 16'h8000, 16'h8000, 32'h40000000, 16'h4000, 40'h0040000000};
    vecs[2] = '{1'b1, 16'h8000, 16'h0001, 32'hFFFF8000, 16'hFFFF, 40'hFFFFFF8000};
    vecs[3] = '{1'b1, 16'hFFFF, 16'h0003, 32'hFFFFFFFD, 16'hFFFF, 40'hFFFFFFFFFD};
    vecs[4] = '{1'b1, 16'h4000, 16'h0004, 32'h00010000, 16'h0001, 40'h0000010000};
    vecs[5] = '{1'b1, 16'hFFFF, 16'h0002, 32'hFFFFFFFE, 16'hFFFF, 40'hFFFFFFFFFE};
    vecs[6] = '{1'b1, 16'h7FFF, 16'h8000, 32'hC0008000, 16'hC000, 40'hFFC0008000};
    vecs[7] = '{1'b0, 16'h8000, 16'h0002, 32'h00010000, 16'h0001, 40'h0000010000};
    vecs[8] = '{1'b0, 16'h0000, 16'h1234, 32'h00000000, 16'h0000, 40'h0000000000};
    vecs[9] = '{1'b1, 16'h0005, 16'hFFFD, 32'hFFFFFFF1, 16'hFFFF, 40'hFFFFFFFFF1};

    rst_n = 1'b0; start = 1'b0; sgn = 1'b0; a = '0; b = '0;
    start3 = 1'b0; sgn3 = 1'b0; a3 = '0; b3 = '0;
    repeat (3) @(negedge clk);
    chk("rst busy", busy0, 0);
    chk("rst done", done0, 0);
    chk("rst res0", res0, 0);
    chk("rst res1", res1, 0);
    chk("rst res2", res2, 0);
    chk("rst res3", res3, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed vectors
    for (int i = 0; i < 10; i++) begin
      launch(vecs[i].s, vecs[i].va, vecs[i].vb);
      chk($sformatf("v%0d busy_after_start", i), busy0, 1);
      wait_check($sformatf("v%0d", i), 1'b0);
      chk($sformatf("v%0d res32", i), res0, vecs[i].e32);
      chk($sformatf("v%0d res16", i), res1, vecs[i].e16);
      chk($sformatf("v%0d res40", i), res2, vecs[i].e40);
      @(negedge clk);
      chk($sformatf("v%0d done_pulse", i), done0, 0);
      chk($sformatf("v%0d res_held", i), res0, vecs[i].e32);
    end

    // Back-to-back: Start presented in the Done cycle
    launch(1'b1, 16'h8000, 16'h8000);
    wait_check("b2b_first", 1'b0);
    chk("b2b_first res", res0, 32'h40000000);
    launch(1'b0, 16'd3, 16'd5);
    wait_check("b2b_second", 1'b0);
    chk("b2b res32", res0, 32'd15);
    chk("b2b res16", res1, 16'd0);
    chk("b2b res40", res2, 40'd15);

    // Start strobed while busy is ignored
    @(negedge clk);
    launch(1'b0, 16'h0100, 16'h0200);
    wait_check("ignore", 1'b1);
    chk("ignore res", res0, 32'h00020000);
    count_dones("ignore extra_dones", 25, 0);

    // Asynchronous clear mid-operation
    launch(1'b0, 16'hFFFF, 16'hFFFF);
    repeat (8) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("aclr busy", busy0, 0);
    chk("aclr done", done0, 0);
    chk("aclr res", res0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    count_dones("aclr no_done", 25, 0);
    launch(1'b0, 16'd3, 16'd5);
    wait_check("after_aclr", 1'b0);
    chk("after_aclr res", res0, 32'd15);

    // Randomised 16x16 operations against an exact-product model
    for (int i = 0; i < 150; i++) begin
      logic s;
      logic [15:0] ra, rb;
      s = 1'($urandom_range(0, 1));
      ra = 16'($urandom);
      rb = 16'($urandom);
      p = s ? 64'(longint'($signed(ra)) * longint'($signed(rb)))
            : 64'(longint'(ra) * longint'(rb));
      @(negedge clk);
      launch(s, ra, rb);
      wait_check("rnd16", 1'b0);
      chk("rnd16 res32", res0, p[31:0]);
      chk("rnd16 res16", res1, p[31:16]);
      chk("rnd16 res40", res2, p[39:0]);
    end

    // Randomised 5x3 -> 12 operations
    for (int i = 0; i < 3000; i++) begin
      sgn3 = 1'($urandom_range(0, 1));
      a3 = 5'($urandom);
      b3 = 3'($urandom);
      p = sgn3 ? 64'(longint'($signed(a3)) * longint'($signed(b3)))
               : 64'(longint'(a3) * longint'(b3));
      start3 = 1'b1;
      @(negedge clk);
      start3 = 1'b0;
      lat3 = 0;
      while (!done3 && lat3 < 20) begin
        @(negedge clk);
        lat3++;
      end
      chk("rnd5x3 latency", lat3, 4);
      chk("rnd5x3 res", res3, p[11:0]);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
